// File: rtl/lq_mem_arbiter_pkg.sv
// ============================================================================
// Module      : lq_mem_arbiter_pkg
// Description : Shared types and constants for the LQ data-side memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lq_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef logic [3:0] MEM_TAG_T;

    localparam int LQ_MEM_TAGS  = 15;
    localparam int LQ_MAX_OUTST = 8;
    localparam int C_BLK_W      = 61;

    function automatic logic [63:0] blk_to_addr(input logic [C_BLK_W-1:0] blk);
        return {blk, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lq_tag_table.sv
// ============================================================================
// Module      : lq_tag_table
// Description : Outstanding-load table indexed by memory tag, with block CAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lq_tag_table
    import lq_mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = LQ_MEM_TAGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [C_BLK_W-1:0] i_match_blk,
    output logic               o_match_hit,
    input  MEM_TAG_T           i_rd_tag,
    output logic               o_rd_valid,
    output logic [C_BLK_W-1:0] o_rd_blk,
    input  logic               i_clr_en,
    input  MEM_TAG_T           i_clr_tag,
    input  logic               i_set_en,
    input  MEM_TAG_T           i_set_tag,
    input  logic [C_BLK_W-1:0] i_set_blk,
    output logic [3:0]         o_count
);

    logic [NUM_TAGS:1]  valid_q;
    logic [NUM_TAGS:1]  valid_d;
    logic [C_BLK_W-1:0] blk_q [1:NUM_TAGS];
    logic [C_BLK_W-1:0] blk_d [1:NUM_TAGS];
    logic [3:0]         count_q;
    logic [3:0]         count_d;

    always_comb begin
        valid_d     = valid_q;
        blk_d       = blk_q;
        o_match_hit = 1'b0;
        o_rd_valid  = 1'b0;
        o_rd_blk    = '0;
        count_d     = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (valid_q[i] && (i_rd_tag == MEM_TAG_T'(i))) begin
                o_rd_valid = 1'b1;
                o_rd_blk   = blk_q[i];
            end
            // An entry retiring this cycle must not absorb a new load: it is refetched.
            if (valid_q[i] && (blk_q[i] == i_match_blk) &&
                !(i_clr_en && (i_clr_tag == MEM_TAG_T'(i))))
                o_match_hit = 1'b1;
            // Clear before set so a tag reissued in the same cycle keeps the new entry.
            if (i_clr_en && (i_clr_tag == MEM_TAG_T'(i)))
                valid_d[i] = 1'b0;
            if (i_set_en && (i_set_tag == MEM_TAG_T'(i))) begin
                valid_d[i] = 1'b1;
                blk_d[i]   = i_set_blk;
            end
        end
        for (int i = 1; i <= NUM_TAGS; i++)
            count_d = count_d + 4'(valid_d[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 1; i <= NUM_TAGS; i++)
                blk_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 1; i <= NUM_TAGS; i++)
                blk_q[i] <= blk_d[i];
        end
    end

    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/lq_mem_arbiter.sv
// ============================================================================
// Module      : lq_mem_arbiter
// Description : Shares the data memory port between LQ misses and store retires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lq_mem_arbiter
    import lq_mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS  = LQ_MEM_TAGS,
    parameter int MAX_OUTST = LQ_MAX_OUTST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_req_valid,
    input  logic [63:0] ld_req_addr,
    output logic        ld_req_ready,
    input  logic        st_req_valid,
    input  logic [63:0] st_req_addr,
    input  logic [63:0] st_req_data,
    output logic        st_req_ready,
    output BUS_COMMAND  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic        lq_miss_valid,
    output logic [63:0] lq_miss_addr,
    output logic [63:0] lq_miss_data,
    output logic [3:0]  outst_count
);

    logic [C_BLK_W-1:0] w_ld_blk;
    logic               w_hit;
    logic               w_rd_valid;
    logic [C_BLK_W-1:0] w_rd_blk;
    logic               w_fill;
    logic               w_ld_merge;
    logic               w_ld_elig;
    logic               w_st_elig;
    logic               w_grant_ld;
    logic               w_grant_st;
    logic               w_accept;
    logic               w_set_en;
    logic               w_unused;

    logic               rr_last_q, rr_last_d;
    logic               miss_valid_q, miss_valid_d;
    logic [63:0]        miss_addr_q, miss_addr_d;
    logic [63:0]        miss_data_q, miss_data_d;

    assign w_ld_blk = ld_req_addr[63:3];
    assign w_unused = ^{ld_req_addr[2:0], st_req_addr[2:0]};
    assign w_fill   = (mem2proc_tag != 4'd0) && w_rd_valid;
    assign w_accept = (mem2proc_response != 4'd0);

    lq_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .i_match_blk (w_ld_blk),
        .o_match_hit (w_hit),
        .i_rd_tag    (mem2proc_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_blk    (w_rd_blk),
        .i_clr_en    (w_fill),
        .i_clr_tag   (mem2proc_tag),
        .i_set_en    (w_set_en),
        .i_set_tag   (mem2proc_response),
        .i_set_blk   (w_ld_blk),
        .o_count     (outst_count)
    );

    // rr_last_q == 1 means the store went last, so a tie goes to the load.
    assign w_ld_merge = ld_req_valid && w_hit;
    assign w_ld_elig  = ld_req_valid && !w_hit && (outst_count < 4'(MAX_OUTST));
    assign w_st_elig  = st_req_valid;
    assign w_grant_ld = w_ld_elig && (!w_st_elig || rr_last_q);
    assign w_grant_st = w_st_elig && !w_grant_ld;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        ld_req_ready     = w_ld_merge;
        st_req_ready     = 1'b0;
        w_set_en         = 1'b0;
        rr_last_d        = rr_last_q;
        if (w_grant_ld) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = blk_to_addr(w_ld_blk);
            ld_req_ready     = w_accept;
            w_set_en         = w_accept;
            if (w_accept)
                rr_last_d = 1'b0;
        end else if (w_grant_st) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = blk_to_addr(st_req_addr[63:3]);
            proc2mem_data    = st_req_data;
            st_req_ready     = w_accept;
            if (w_accept)
                rr_last_d = 1'b1;
        end
        miss_valid_d = w_fill;
        miss_addr_d  = w_fill ? blk_to_addr(w_rd_blk) : 64'd0;
        miss_data_d  = w_fill ? mem2proc_data : 64'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q    <= 1'b1;
            miss_valid_q <= 1'b0;
            miss_addr_q  <= '0;
            miss_data_q  <= '0;
        end else begin
            rr_last_q    <= rr_last_d;
            miss_valid_q <= miss_valid_d;
            miss_addr_q  <= miss_addr_d;
            miss_data_q  <= miss_data_d;
        end
    end

    assign lq_miss_valid = miss_valid_q;
    assign lq_miss_addr  = miss_addr_q;
    assign lq_miss_data  = miss_data_q;

endmodule

`default_nettype wire
